// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared instruction/data memory port.
// Data side has priority; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data wins over a pending fetch. One access in flight.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  if (MEM_LAT < 1) begin : gen_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end
  if (MEM_LAT >= (2 ** CNT_W) || STARVE_MAX >= (2 ** CNT_W)) begin : gen_bad_cnt_w
    $error("mem_port_arbiter: CNT_W too narrow for MEM_LAT/STARVE_MAX");
  end

  localparam logic [CNT_W-1:0] LatLast   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] StarveTop = CNT_W'(STARVE_MAX);

  typedef enum logic {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;  // 1 = data port owns the access
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d, mem_en_q, mem_en_d;
  logic             if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic             mem_we_q, mem_we_d;
  logic [63:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [63:0]      d_rdata_q, d_rdata_d;
  logic             win_d, win_i;

  // Arbitration, next state and registered-output next values.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    lat_d       = lat_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    mem_en_d    = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    // Fetch overrides data only once it has been passed over STARVE_MAX times.
    win_d = d_req && !(if_req && (starve_q == StarveTop));
    win_i = !win_d && if_req;
    unique case (state_q)
      StIdle: begin
        if (win_d || win_i) begin
          state_d     = StWait;
          lat_d       = CNT_W'(1);
          owner_d     = win_d;
          mem_en_d    = 1'b1;
          if_gnt_d    = win_i;
          d_gnt_d     = win_d;
          mem_addr_d  = win_d ? d_addr : if_addr;
          mem_we_d    = win_d && d_we;
          mem_wdata_d = win_d ? d_wdata : 64'd0;
          if (win_i) begin
            starve_d = '0;
          end else if (if_req && (starve_q != StarveTop)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end
      StWait: begin
        if (lat_q == LatLast) begin
          state_d = StIdle;
          lat_d   = '0;
          if (owner_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_we_q ? 64'd0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata[31:0];
          end
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b1;
      starve_q    <= '0;
      lat_q       <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      lat_q       <= lat_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      mem_en_q    <= mem_en_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Output mapping.
  always_comb begin
    if_gnt    = if_gnt_q;
    d_gnt     = d_gnt_q;
    mem_en    = mem_en_q;
    if_rvalid = if_rvalid_q;
    d_rvalid  = d_rvalid_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    busy      = (state_q == StWait);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) share random
// stimulus; each is checked every cycle against a transaction-schedule model.
module tb_mem_port_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        log_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int L = (g == 0) ? 1 : 3;

    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata;
    logic [63:0] d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [63:0] mem [16];

    mem_port_arbiter #(.MEM_LAT(L), .STARVE_MAX(SM), .CNT_W(3)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory: data stays valid for as long as mem_addr is held.
    assign mem_rdata = mem[mem_addr[6:3]];
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[6:3]] <= mem_wdata;
    initial for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};

    // Model state: when the port frees up and which response is due when.
    int          cyc = 0, free_at = 0, pend_cyc = 0, starve = 0, log_n = 0;
    bit          pend = 0, pend_d = 0, pend_we = 0, wd, wi;
    logic [3:0]  pend_idx;
    logic [63:0] a;
    bit          glog[$];
    logic        e_if_gnt = 0, e_d_gnt = 0, e_mem_en = 0, e_if_rv = 0, e_d_rv = 0;
    logic        e_mem_we = 0, e_busy = 0;
    logic [63:0] e_mem_addr = '0, e_mem_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;

    always begin
      @(posedge clk);
      cyc++;
      #1;
      check($sformatf("L%0d if_gnt", L), if_gnt, e_if_gnt);
      check($sformatf("L%0d d_gnt", L), d_gnt, e_d_gnt);
      check($sformatf("L%0d mem_en", L), mem_en, e_mem_en);
      check($sformatf("L%0d if_rvalid", L), if_rvalid, e_if_rv);
      check($sformatf("L%0d d_rvalid", L), d_rvalid, e_d_rv);
      check($sformatf("L%0d busy", L), busy, e_busy);
      check($sformatf("L%0d mem_we", L), mem_we, e_mem_we);
      check($sformatf("L%0d mem_addr", L), mem_addr, e_mem_addr);
      check($sformatf("L%0d mem_wdata", L), mem_wdata, e_mem_wdata);
      check($sformatf("L%0d if_rdata", L), {32'd0, if_rdata}, e_if_rdata);
      check($sformatf("L%0d d_rdata", L), d_rdata, e_d_rdata);
      if (log_en && log_n < 10 && (d_gnt || if_gnt)) begin
        glog.push_back(d_gnt);
        log_n++;
        if (log_n == 10)
          for (int i = 0; i < 10; i++)
            check($sformatf("L%0d grant order %0d (1=D)", L, i), glog[i], (i % 5 == 4) ? 0 : 1);
      end
      #2;
      if (!reset) begin
        check($sformatf("L%0d rst gnt/en/rv/busy", L),
              {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid, busy, mem_we}, 0);
        check($sformatf("L%0d rst data", L),
              mem_addr | mem_wdata | d_rdata | {32'd0, if_rdata}, 0);
        pend = 0; free_at = cyc + 1; starve = 0;
        {e_if_gnt, e_d_gnt, e_mem_en, e_if_rv, e_d_rv, e_mem_we, e_busy} = '0;
        e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
      end else begin
        {e_if_gnt, e_d_gnt, e_mem_en, e_if_rv, e_d_rv} = '0;
        if (pend && pend_cyc == cyc + 1) begin
          pend = 0;
          if (pend_d) begin
            e_d_rv = 1;
            e_d_rdata = pend_we ? 64'd0 : mem[pend_idx];
          end else begin
            e_if_rv = 1;
            a = mem[pend_idx];
            e_if_rdata = {32'd0, a[31:0]};
          end
        end
        if (cyc >= free_at) begin
          wd = d_req && !(if_req && starve == SM);
          wi = !wd && if_req;
          if (wd || wi) begin
            if (wi) starve = 0;
            else if (if_req) starve = (starve < SM) ? starve + 1 : SM;
            a = wd ? d_addr : if_addr;
            e_if_gnt = wi; e_d_gnt = wd; e_mem_en = 1;
            e_mem_addr = a;
            e_mem_we = wd && d_we;
            e_mem_wdata = wd ? d_wdata : 64'd0;
            pend = 1; pend_d = wd; pend_we = wd && d_we; pend_idx = a[6:3];
            pend_cyc = cyc + 1 + L; free_at = cyc + 1 + L;
          end
        end
        e_busy = (cyc + 1 < free_at);
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    repeat (3) step();
    // Single fetch, then a single store.
    reset = 1'b1; if_req = 1'b1; if_addr = 64'h2000;
    step(); if_req = 1'b0;
    repeat (5) step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEAD_BEEF;
    step(); d_req = 1'b0; d_we = 1'b0;
    repeat (6) step();
    // Both requesters held high from a clean reset: starvation pattern.
    reset = 1'b0;
    step(); step();
    reset = 1'b1; log_en = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 64'h40; d_addr = 64'h58;
    repeat (50) step();
    log_en = 1'b0;
    // Random traffic with occasional mid-flight resets.
    for (int i = 0; i < 3000; i++) begin
      if_req  = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 3) != 0);
      d_we    = $urandom_range(0, 1) == 1;
      if_addr = {$urandom, $urandom};
      d_addr  = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom};
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 79) == 0) reset = 1'b0;
      step();
    end
    // Back-to-back loads.
    reset = 1'b1; if_req = 1'b0; d_req = 1'b1; d_we = 1'b0;
    repeat (25) begin
      step();
      d_addr = {$urandom, $urandom};
    end
    d_req = 1'b0;
    repeat (6) step();
    check("L1 starvation grants logged", g_lat[0].log_n, 10);
    check("L3 starvation grants logged", g_lat[1].log_n, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
